timer0_ctrl: RTL and testbench
==============================

# timer0_ctrl

Timer0 control and register block for the PIC16F1826 core. It owns the TMR0 and OPTION_REG special-function registers on the SFR bus and synchronises and edge-detects the T0CKI pin. It sequences the prescaler, applies the post-write increment inhibit, and keeps the sticky T0IF overflow flag consumed by the interrupt controller. It sits between the core's SFR read/write port and the interrupt logic.

## Interface

Parameters:
- None. Widths are fixed by the PIC16F1826 register map.

Ports:
- clock  in  1  instruction-cycle clock (Fosc/4); all state updates on its rising edge
- reset  in  1  reset reset, synchronous, active-high; clock clock
- t0cki  in  1  raw RA4/T0CKI pin, asynchronous
- bus_addr  in  9  SFR address {bank[1:0], offset[6:0]}; TMR0 = 9'h015, OPTION_REG = 9'h095, INTCON = offset 7'h0B in any bank
- bus_wdata  in  8  SFR write data
- bus_we  in  1  write strobe, one cycle per write
- bus_rdata  out  8  combinational read data; TMR0 at 9'h015, OPTION_REG at 9'h095, 8'h00 at any other address
- t0ie  in  1  INTCON.T0IE, owned by the interrupt controller
- t0if  out  1  INTCON.T0IF, sticky overflow flag
- t0_irq  out  1  t0if & t0ie, combinational

## Operation

OPTION_REG fields:
- [5] T0CS: 0 = internal tick every clock; 1 = external edge.
- [4] T0SE: 0 = rising edge of T0CKI; 1 = falling edge.
- [3] PSA: 1 = prescaler bypassed.
- [2:0] PS: prescale ratio is 2^(PS+1), i.e. 1:2 to 1:256.

External path:
- t0cki passes through two flops (s1, s2), then a history flop s3.
- Rising edge = s2 & ~s3. Falling edge = ~s2 & s3.
- Edge detection is active only when T0CS=1.

Tick handling:
- PSA=1: every tick increments TMR0 by 1 (mod 256).
- PSA=0: every tick increments the 8-bit prescaler count.
  - When the count equals ratio-1 on a tick, the count goes to 0 and TMR0 increments.

Overflow:
- An increment from 8'hFF gives 8'h00 and sets t0if on the same edge.
- t0if clears only on an INTCON write with bus_wdata[2]=0. A write with bus_wdata[2]=1 sets it.
- Overflow set and software clear on the same edge: set wins, t0if=1.

Writes:
- TMR0 write: TMR0 takes bus_wdata, the prescaler count goes to 0, and the state goes to INH1.
- OPTION_REG write: new value takes effect from the next edge, and the prescaler count goes to 0.
  - A tick on the same edge as the OPTION_REG write is discarded.

Inhibit state machine: RUN, INH1, INH2.
- RUN → INH1 on a TMR0 write.
- INH1 → INH2 unconditionally.
- INH2 → RUN unconditionally.
- A TMR0 write in INH1 or INH2 returns the state to INH1.
- In INH1 and INH2, ticks are discarded: no prescaler or TMR0 change and no overflow.
- A TMR0 write on the same edge as an increment or overflow: the write wins, and t0if is not set by that edge.

Reset values:
- TMR0=8'h00, OPTION_REG=8'hFF, prescaler count 0.
- t0if=0, t0_irq=0, state RUN, s1/s2/s3=0.
- Reset has priority over all bus writes. Reset during INH1/INH2 or mid-prescale abandons the sequence.

## Timing

- Internal clock, PSA=1, TMR0 written at edge N: TMR0 holds the written value after edges N+1 and N+2. The first increment is at edge N+3.
- External clock: a pin transition sampled by s1 at edge K increments TMR0 (or the prescaler) at edge K+2.
  - Pin high/low time must each be at least 1 clock period. Narrower pulses may be missed.
- t0if rises on the same edge TMR0 wraps to 8'h00. t0_irq follows combinationally.
- Register reads are combinational from current state, with no read side effects. A same-cycle write is visible on the next cycle.

## Test plan

- Reset: assert reset for 2 edges → bus_rdata=8'hFF at 9'h095, 8'h00 at 9'h015; t0if=0, t0_irq=0.
- Internal, no prescale: OPTION=8'h08, then TMR0=8'hFD at edge N → TMR0 is FD at N+1 and N+2, FE at N+3, FF at N+4, 00 at N+5 with t0if=1; t0_irq=1 only while t0ie=1.
- Prescale 1:4: OPTION=8'h01, TMR0=8'h10 at edge N → TMR0 becomes 11 at N+6, 12 at N+10, 13 at N+14.
- External edge: OPTION=8'h28, 5 pin rising edges spaced 4 clocks → TMR0 +5, each increment 2 edges after the sampling edge. Then OPTION=8'h38 → increments only on falling edges; no increment during INH after a TMR0 write.
- Collision: TMR0=8'hFF with OPTION=8'h08, INTCON write bus_wdata=8'h00 on the wrap edge → t0if=1. A following INTCON clear → t0if=0.
- Reset mid-operation: OPTION=8'h07, after 100 ticks assert reset → TMR0=00, OPTION=FF, prescaler 0. After release, no increment until the first external edge.

Source files
------------

// File: rtl/timer0_ctrl.sv
// Timer0 register block: TMR0/OPTION_REG on the SFR bus, T0CKI synchroniser,
// prescaler, post-write increment inhibit and the sticky T0IF overflow flag.
module timer0_ctrl (
   input  logic       clock,
   input  logic       reset,
   input  logic       t0cki,
   input  logic [8:0] bus_addr,
   input  logic [7:0] bus_wdata,
   input  logic       bus_we,
   output logic [7:0] bus_rdata,
   input  logic       t0ie,
   output logic       t0if,
   output logic       t0_irq
);

   typedef enum logic [1:0] {RUN, INH1, INH2} inh_state_t;

   localparam logic [8:0] TMR0_ADDR     = 9'h015;
   localparam logic [8:0] OPTION_ADDR   = 9'h095;
   localparam logic [6:0] INTCON_OFFSET = 7'h0B;

   inh_state_t state, state_next;

   logic [7:0] tmr0, tmr0_next;
   logic [7:0] option_reg;
   logic [7:0] pre_cnt, pre_next;
   logic       t0if_next;
   logic       s1, s2, s3;

   logic       tmr0_we, option_we, intcon_we;
   logic       ext_edge, tick, run_tick, inc;
   logic [7:0] ratio_m1;

   always_comb begin
      tmr0_we   = bus_we && (bus_addr == TMR0_ADDR);
      option_we = bus_we && (bus_addr == OPTION_ADDR);
      intcon_we = bus_we && (bus_addr[6:0] == INTCON_OFFSET);
   end

   // Ticks that land in the inhibit window or on an OPTION_REG write are dropped.
   always_comb begin
      ext_edge = option_reg[4] ? (~s2 & s3) : (s2 & ~s3);
      tick     = option_reg[5] ? ext_edge : 1'b1;
      run_tick = tick && (state == RUN) && !option_we && !tmr0_we;
      ratio_m1 = 8'hFF >> (3'd7 - option_reg[2:0]);
   end

   always_comb begin
      inc       = 1'b0;
      pre_next  = pre_cnt;
      tmr0_next = tmr0;
      t0if_next = t0if;
      if (run_tick) begin
         if (option_reg[3]) begin
            inc = 1'b1;
         end else if (pre_cnt == ratio_m1) begin
            pre_next = 8'h00;
            inc      = 1'b1;
         end else begin
            pre_next = pre_cnt + 8'd1;
         end
      end
      if (inc) begin
         tmr0_next = tmr0 + 8'd1;
      end
      if (intcon_we) begin
         t0if_next = bus_wdata[2];
      end
      // A hardware overflow outranks a software clear on the same edge.
      if (inc && (tmr0 == 8'hFF)) begin
         t0if_next = 1'b1;
      end
      if (tmr0_we) begin
         tmr0_next = bus_wdata;
         pre_next  = 8'h00;
      end
      if (option_we) begin
         pre_next = 8'h00;
      end
   end

   always_comb begin
      state_next = RUN;
      case (state)
         RUN:     state_next = RUN;
         INH1:    state_next = INH2;
         INH2:    state_next = RUN;
         default: state_next = RUN;
      endcase
      if (tmr0_we) begin
         state_next = INH1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tmr0       <= 8'h00;
         option_reg <= 8'hFF;
         pre_cnt    <= 8'h00;
         t0if       <= 1'b0;
         s1         <= 1'b0;
         s2         <= 1'b0;
         s3         <= 1'b0;
      end else begin
         tmr0    <= tmr0_next;
         pre_cnt <= pre_next;
         t0if    <= t0if_next;
         s1      <= t0cki;
         s2      <= s1;
         s3      <= s2;
         if (option_we) begin
            option_reg <= bus_wdata;
         end
      end
   end

   always_comb begin
      case (bus_addr)
         TMR0_ADDR:   bus_rdata = tmr0;
         OPTION_ADDR: bus_rdata = option_reg;
         default:     bus_rdata = 8'h00;
      endcase
   end

   assign t0_irq = t0if & t0ie;

endmodule

// File: tb/tb_timer0_ctrl.sv
// Self-checking bench for timer0_ctrl: a cycle-level reference model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_timer0_ctrl;

   logic       clock;
   logic       reset;
   logic       t0cki;
   logic [8:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic [7:0] bus_rdata;
   logic       t0ie;
   logic       t0if;
   logic       t0_irq;

   int nCompared   = 0;
   int nMismatched = 0;

   timer0_ctrl dut (
      .clock     (clock),
      .reset     (reset),
      .t0cki     (t0cki),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_we    (bus_we),
      .bus_rdata (bus_rdata),
      .t0ie      (t0ie),
      .t0if      (t0if),
      .t0_irq    (t0_irq)
   );

   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   // Reference model: pin transitions become due two cycles after sampling,
   // and a write opens a two-cycle window in which ticks are ignored.
   logic [7:0] mTmr0;
   logic [7:0] mOpt;
   int         mPre;
   int         mInh;
   bit         mT0if;
   bit         modelValid = 1'b0;
   int         cyc = 0;
   bit         prevPin;
   int         dueQ[$];
   bit         polQ[$];
   bit         extTick, tickNow, incNow, ovfNow, twe, owe, iwe;

   always @(posedge clock) begin
      cyc++;
      if (reset) begin
         mTmr0 = 8'h00;
         mOpt  = 8'hFF;
         mPre  = 0;
         mInh  = 0;
         mT0if = 1'b0;
         prevPin = 1'b0;
         dueQ.delete();
         polQ.delete();
         modelValid = 1'b1;
      end else begin
         extTick = 1'b0;
         foreach (dueQ[i]) begin
            if (dueQ[i] == cyc && polQ[i] == !mOpt[4]) extTick = 1'b1;
         end
         while (dueQ.size() > 0 && dueQ[0] <= cyc) begin
            void'(dueQ.pop_front());
            void'(polQ.pop_front());
         end
         if (t0cki != prevPin) begin
            dueQ.push_back(cyc + 2);
            polQ.push_back(t0cki);
         end
         prevPin = t0cki;

         twe = bus_we && bus_addr == 9'h015;
         owe = bus_we && bus_addr == 9'h095;
         iwe = bus_we && bus_addr[6:0] == 7'h0B;
         tickNow = mOpt[5] ? extTick : 1'b1;
         incNow  = 1'b0;
         if (mInh > 0) begin
            mInh--;
         end else if (tickNow && !owe && !twe) begin
            if (mOpt[3]) begin
               incNow = 1'b1;
            end else begin
               mPre++;
               if (mPre == (1 << (int'(mOpt[2:0]) + 1))) begin
                  mPre   = 0;
                  incNow = 1'b1;
               end
            end
         end
         ovfNow = incNow && mTmr0 == 8'hFF;
         if (incNow) mTmr0 = 8'((int'(mTmr0) + 1) % 256);
         if (iwe) mT0if = bus_wdata[2];
         if (ovfNow) mT0if = 1'b1;
         if (twe) begin
            mTmr0 = bus_wdata;
            mPre  = 0;
            mInh  = 2;
         end
         if (owe) begin
            mOpt = bus_wdata;
            mPre = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   logic [7:0] expRdata;
   always @(negedge clock) begin
      if (modelValid) begin
         case (bus_addr)
            9'h015:  expRdata = mTmr0;
            9'h095:  expRdata = mOpt;
            default: expRdata = 8'h00;
         endcase
         checkOutput("cycle_rdata", bus_rdata, expRdata);
         checkOutput("cycle_t0if", {7'b0, t0if}, {7'b0, mT0if});
         checkOutput("cycle_t0_irq", {7'b0, t0_irq}, {7'b0, mT0if & t0ie});
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [8:0] addr, input logic [7:0] data);
      bus_addr  = addr;
      bus_wdata = data;
      bus_we    = 1'b1;
      step();
      bus_we    = 1'b0;
      bus_addr  = 9'h015;
      bus_wdata = 8'h00;
   endtask

   task automatic readCheck(input logic [8:0] addr, input logic [7:0] expected,
                            input string name);
      bus_addr = addr;
      #1;
      checkOutput(name, bus_rdata, expected);
      bus_addr = 9'h015;
   endtask

   task automatic checkTmr(input logic [7:0] expected, input string name);
      readCheck(9'h015, expected, name);
   endtask

   initial begin
      reset = 1'b1;
      t0cki = 1'b0;
      bus_addr = 9'h015;
      bus_wdata = 8'h00;
      bus_we = 1'b0;
      t0ie = 1'b0;

      // Reset state
      step();
      step();
      reset = 1'b0;
      readCheck(9'h095, 8'hFF, "reset_option");
      readCheck(9'h015, 8'h00, "reset_tmr0");
      checkOutput("reset_t0if", {7'b0, t0if}, 8'h00);
      checkOutput("reset_t0_irq", {7'b0, t0_irq}, 8'h00);

      // Internal clock, no prescale, inhibit window and wrap
      applyStimulus(9'h095, 8'h08);
      applyStimulus(9'h015, 8'hFD);
      checkTmr(8'hFD, "int_edge_n");
      step(); checkTmr(8'hFD, "int_edge_n1");
      step(); checkTmr(8'hFD, "int_edge_n2");
      step(); checkTmr(8'hFE, "int_edge_n3");
      step(); checkTmr(8'hFF, "int_edge_n4");
      step(); checkTmr(8'h00, "int_wrap");
      checkOutput("wrap_t0if", {7'b0, t0if}, 8'h01);
      checkOutput("wrap_irq_masked", {7'b0, t0_irq}, 8'h00);
      t0ie = 1'b1;
      #1;
      checkOutput("wrap_irq_enabled", {7'b0, t0_irq}, 8'h01);
      t0ie = 1'b0;
      applyStimulus(9'h00B, 8'h00);
      checkOutput("intcon_clear", {7'b0, t0if}, 8'h00);

      // Prescale 1:4
      applyStimulus(9'h095, 8'h01);
      applyStimulus(9'h015, 8'h10);
      repeat (5) step();
      checkTmr(8'h10, "pre_n5");
      step(); checkTmr(8'h11, "pre_n6");
      repeat (4) step();
      checkTmr(8'h12, "pre_n10");
      repeat (4) step();
      checkTmr(8'h13, "pre_n14");

      // External rising edges
      applyStimulus(9'h095, 8'h28);
      applyStimulus(9'h015, 8'h40);
      repeat (3) step();
      for (int i = 0; i < 5; i++) begin
         t0cki = 1'b1;
         step(); checkTmr(8'(8'h40 + i), "ext_rise_k");
         step(); checkTmr(8'(8'h40 + i), "ext_rise_k1");
         step(); checkTmr(8'(8'h41 + i), "ext_rise_k2");
         t0cki = 1'b0;
         step();
      end
      repeat (3) step();
      checkTmr(8'h45, "ext_rise_total");

      // External falling edges, then a falling edge lost to the inhibit window
      applyStimulus(9'h095, 8'h38);
      t0cki = 1'b1;
      repeat (3) step();
      checkTmr(8'h45, "ext_fall_ignores_rise");
      t0cki = 1'b0;
      step(); checkTmr(8'h45, "ext_fall_k");
      step(); checkTmr(8'h45, "ext_fall_k1");
      step(); checkTmr(8'h46, "ext_fall_k2");
      t0cki = 1'b1;
      repeat (3) step();
      t0cki = 1'b0;
      step();
      applyStimulus(9'h015, 8'h80);
      checkTmr(8'h80, "inh_write");
      step(); checkTmr(8'h80, "inh_drop_n1");
      step(); checkTmr(8'h80, "inh_drop_n2");
      step(); checkTmr(8'h80, "inh_drop_n3");

      // Overflow versus software clear on the same edge
      applyStimulus(9'h00B, 8'h00);
      applyStimulus(9'h095, 8'h08);
      applyStimulus(9'h015, 8'hFF);
      step();
      step();
      checkTmr(8'hFF, "coll_pre_wrap");
      applyStimulus(9'h00B, 8'h00);
      checkTmr(8'h00, "coll_wrap");
      checkOutput("coll_set_wins", {7'b0, t0if}, 8'h01);
      applyStimulus(9'h00B, 8'h00);
      checkOutput("coll_later_clear", {7'b0, t0if}, 8'h00);
      applyStimulus(9'h00B, 8'h04);
      checkOutput("intcon_sw_set", {7'b0, t0if}, 8'h01);
      applyStimulus(9'h00B, 8'h00);
      checkOutput("intcon_sw_clear", {7'b0, t0if}, 8'h00);

      // TMR0 write on the wrap edge suppresses the overflow
      applyStimulus(9'h015, 8'hFF);
      step();
      step();
      applyStimulus(9'h015, 8'h55);
      checkTmr(8'h55, "write_wins_value");
      checkOutput("write_wins_no_t0if", {7'b0, t0if}, 8'h00);
      step();
      step();
      checkTmr(8'h55, "write_wins_inh");
      step(); checkTmr(8'h56, "write_wins_resume");

      // Reset in the middle of a long prescale
      applyStimulus(9'h095, 8'h07);
      repeat (100) step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      readCheck(9'h015, 8'h00, "midreset_tmr0");
      readCheck(9'h095, 8'hFF, "midreset_option");
      checkOutput("midreset_t0if", {7'b0, t0if}, 8'h00);
      repeat (10) step();
      checkTmr(8'h00, "midreset_idle");
      t0cki = 1'b1;
      repeat (3) step();
      checkTmr(8'h00, "midreset_rise_ignored");
      t0cki = 1'b0;
      step();
      step(); checkTmr(8'h00, "midreset_fall_k1");
      step(); checkTmr(8'h01, "midreset_fall_k2");

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
